// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed XLEN+1 cycle latency with valid/ready request and response handshakes.
module mul_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_in1,
    input  logic [XLEN-1:0] req_in2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int unsigned CntW = $clog2(XLEN);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef enum logic [1:0] {StIdle, StSetup, StCompute, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     in1_q, in1_d;
    logic [XLEN-1:0]     in2_q, in2_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;

    logic                is_mul;
    logic                sign1_en, sign2_en;
    logic                in1_neg, in2_neg;
    logic [XLEN-1:0]     abs1, abs2;
    logic                div_zero;
    logic [XLEN:0]       add_sum;
    logic [XLEN:0]       shifted;
    logic [XLEN:0]       diff;
    logic                ge;
    logic [XLEN-1:0]     rem_new;
    logic [2*XLEN-1:0]   step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo, rem;
    logic [XLEN-1:0]     final_res;

    // Operand conditioning, evaluated from the captured request during SETUP.
    always_comb begin
        is_mul   = ~op_q[2];
        sign1_en = (op_q == OpMul) || (op_q == OpMulh) || (op_q == OpMulhsu) ||
                   (op_q == OpDiv) || (op_q == OpRem);
        sign2_en = (op_q == OpMul) || (op_q == OpMulh) || (op_q == OpDiv) || (op_q == OpRem);
        in1_neg  = sign1_en & in1_q[XLEN-1];
        in2_neg  = sign2_en & in2_q[XLEN-1];
        abs1     = in1_neg ? -in1_q : in1_q;
        abs2     = in2_neg ? -in2_q : in2_q;
        div_zero = (in2_q == '0);
    end

    // One iteration. acc holds {product_hi, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};
        ge      = (shifted >= {1'b0, opnd_q});
        rem_new = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        if (is_mul) begin
            step = {add_sum, acc_q[XLEN-1:1]};
        end else begin
            step = {rem_new, acc_q[XLEN-2:0], ge};
        end
    end

    // Sign correction of the value produced by the final iteration.
    always_comb begin
        prod_fix = neg_q ? -step : step;
        quo      = step[XLEN-1:0];
        rem      = step[2*XLEN-1:XLEN];
        case (op_q)
            OpMul:                     final_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             final_res = neg_q ? -quo : quo;
            OpRem, OpRemu:             final_res = rem_neg_q ? -rem : rem;
            default:                   final_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = ~kill;
                if (req_valid && !kill) begin
                    op_d    = req_op;
                    in1_d   = req_in1;
                    in2_d   = req_in2;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                opnd_d    = is_mul ? abs1 : abs2;
                acc_d     = {{XLEN{1'b0}}, (is_mul ? abs2 : abs1)};
                cnt_d     = CntW'(XLEN - 1);
                // A zero divisor yields an all-ones quotient that must not be negated.
                neg_d     = (in1_neg ^ in2_neg) & (is_mul | ~div_zero);
                rem_neg_d = in1_neg;
                state_d   = StCompute;
            end
            StCompute: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase

        if (kill) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign resp_result = result_q;

endmodule

// File: tb/tb_mul_div.sv
// Self-checking bench for mul_div: directed RV32M vectors, random ops against an
// arithmetic reference model, latency, backpressure, kill and asynchronous reset.
module tb_mul_div;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = XLEN + 1;

    logic            clk;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_in1;
    logic [XLEN-1:0] req_in2;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    int n_pass   = 0;
    int n_checks = 0;

    mul_div #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present one request at a negedge; the accepting edge is the following posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit seen_ready);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_in1   = a;
        req_in2   = b;
        #1 seen_ready = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_in1   = $urandom;
        req_in2   = $urandom;
    endtask

    // Count edges after acceptance until resp_valid is seen; ends at a negedge.
    task automatic wait_resp(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
    endtask

    task automatic take();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_in1    = '0;
        req_in2    = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0) begin
            $display("FAIL reset_during: got ready=%b valid=%b result=%h required 1 0 0",
                     req_ready, resp_valid, resp_result);
        end else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0) begin
            $display("FAIL reset_after: got ready=%b valid=%b result=%h required 1 0 0",
                     req_ready, resp_valid, resp_result);
        end else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                                  3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                                  32'd100, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
                                  32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        bit rdy;
        bit got;
        int lat;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], rdy);
            wait_resp(lat, got);
            n_checks++;
            if (!rdy || !got || lat != LAT) begin
                $display("FAIL directed_latency[%0d]: got ready=%b valid=%b lat=%0d required lat=%0d",
                         i, rdy, got, lat, LAT);
            end else n_pass++;
            n_checks++;
            if (resp_result !== exp[i]) begin
                $display("FAIL directed_result[%0d] op=%0d: got %h required %h",
                         i, ops[i], resp_result, exp[i]);
            end else n_pass++;
            take();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        bit rdy;
        bit got;
        int lat;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            e  = model(op, a, b);
            issue(op, a, b, rdy);
            wait_resp(lat, got);
            n_checks++;
            if (!rdy || !got || lat != LAT || resp_result !== e) begin
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d required %h lat=%0d",
                         i, op, a, b, resp_result, lat, e, LAT);
            end else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        bit rdy;
        bit got;
        int lat;
        e = model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy);
        wait_resp(lat, got);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_result !== e || req_ready !== 1'b0) begin
                $display("FAIL backpressure[%0d]: got valid=%b result=%h ready=%b required 1 %h 0",
                         i, resp_valid, resp_result, req_ready, e);
            end else n_pass++;
            @(negedge clk);
        end
        take();
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL after_take: got valid=%b ready=%b required 0 1", resp_valid, req_ready);
        end else n_pass++;
    endtask

    task automatic test_operand_capture();
        bit rdy;
        bit got;
        int lat;
        // issue() scrambles the request inputs straight after acceptance.
        issue(3'd5, 32'd1000, 32'd7, rdy);
        req_valid = 1'b0;
        wait_resp(lat, got);
        n_checks++;
        if (!got || resp_result !== 32'd142) begin
            $display("FAIL operand_capture: got %h required %h", resp_result, 32'd142);
        end else n_pass++;
        take();
    endtask

    // resp_ready held high throughout; next request issued the cycle after the handshake.
    task automatic test_back_to_back();
        bit rdy;
        bit got;
        int lat;
        resp_ready = 1'b1;
        issue(3'd0, 32'd1234, 32'd5678, rdy);
        wait_resp(lat, got);
        n_checks++;
        if (!got || lat != LAT || resp_result !== 32'd7006652) begin
            $display("FAIL b2b_first: got %h lat=%0d required %h lat=%0d",
                     resp_result, lat, 32'd7006652, LAT);
        end else n_pass++;
        issue(3'd6, 32'hFFFF_FF9C, 32'd7, rdy);
        n_checks++;
        if (!rdy) begin
            $display("FAIL b2b_accept: got ready=%b required 1", rdy);
        end else n_pass++;
        wait_resp(lat, got);
        n_checks++;
        if (!got || lat != LAT || resp_result !== 32'hFFFF_FFFE) begin
            $display("FAIL b2b_second: got %h lat=%0d required %h lat=%0d",
                     resp_result, lat, 32'hFFFF_FFFE, LAT);
        end else n_pass++;
        take();
    endtask

    task automatic test_kill();
        bit rdy;
        bit got;
        int lat;
        bit rose;
        issue(3'd4, 32'd1000, 32'd3, rdy);
        // Accepting edge already passed; COMPUTE is entered on the next edge.
        repeat (5) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            $display("FAIL kill_to_idle: got ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end else n_pass++;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) rose = 1'b1;
        end
        n_checks++;
        if (rose) begin
            $display("FAIL kill_no_resp: got resp_valid=1 required 0");
        end else n_pass++;
        issue(3'd6, 32'd1000, 32'hFFFF_FFFD, rdy);
        wait_resp(lat, got);
        n_checks++;
        if (!rdy || !got || lat != LAT || resp_result !== 32'd1) begin
            $display("FAIL kill_next_op: got %h lat=%0d required %h lat=%0d",
                     resp_result, lat, 32'd1, LAT);
        end else n_pass++;
        take();
    endtask

    task automatic test_kill_idle();
        bit bad_valid;
        bit bad_ready;
        @(negedge clk);
        kill      = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_in1   = 32'd3;
        req_in2   = 32'd4;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL kill_idle_ready: got %b required 0", req_ready);
        end else n_pass++;
        @(posedge clk);
        #1;
        kill       = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        bad_valid  = 1'b0;
        bad_ready  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) bad_valid = 1'b1;
            if (!req_ready) bad_ready = 1'b1;
        end
        resp_ready = 1'b0;
        n_checks++;
        if (bad_valid || bad_ready) begin
            $display("FAIL kill_idle_not_accepted: got valid_seen=%b busy_seen=%b required 0 0",
                     bad_valid, bad_ready);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        bit rdy;
        bit got;
        int lat;
        issue(3'd0, 32'd3, 32'd4, rdy);
        wait_resp(lat, got);
        take();
        issue(3'd5, 32'd999, 32'd9, rdy);
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0) begin
            $display("FAIL async_reset: got ready=%b valid=%b result=%h required 1 0 0",
                     req_ready, resp_valid, resp_result);
        end else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        issue(3'd7, 32'd999, 32'd10, rdy);
        wait_resp(lat, got);
        n_checks++;
        if (!rdy || !got || lat != LAT || resp_result !== 32'd9) begin
            $display("FAIL post_reset_op: got %h lat=%0d required %h lat=%0d",
                     resp_result, lat, 32'd9, LAT);
        end else n_pass++;
        take();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_operand_capture();
        test_backpressure();
        test_back_to_back();
        test_kill();
        test_kill_idle();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
